led_blink_decoder: RTL
======================

Name: led_blink_decoder

Overview:
- Receive end of the Fibonacci LED blink link: samples a single-wire blink train on `led_in` and counts qualified high pulses in a burst.
- A long low gap closes the burst; the block then presents the pulse count on `count_out` with a one-cycle `valid_out` strobe.
- Used as a loopback checker beside the Fibonacci datapath and as a standalone decoder on boards that watch a neighbour's LED.

Parameters:
- COUNT_WIDTH, 4, width of blink counter and `count_out`.
- TIMER_WIDTH, 14, width of internal width/gap timer; must hold MAX_PULSE+1 and GAP_CYCLES.
- MIN_PULSE, 800, minimum high length in cycles counted as a blink; shorter is a glitch.
- MAX_PULSE, 3200, maximum legal high length; longer is an error.
- GAP_CYCLES, 4000, consecutive low cycles that end a burst.

Ports:
- clock_in  input  1  system clock.
- reset_in  input  1  asynchronous, active-low reset.
- led_in  input  1  asynchronous blink input.
- count_out  output  COUNT_WIDTH  decoded blink count; held until the next decode.
- valid_out  output  1  one-cycle strobe; `count_out` is new this cycle.
- error_out  output  1  one-cycle strobe on a protocol error.
- busy_out  output  1  high while a burst is in progress (state HIGH or LOW).

Behaviour:
- Reset (reset_in=0, async): state IDLE; synchronizer flops 0; timer 0; blink count 0; `count_out`=0; `valid_out`=0; `error_out`=0; `busy_out`=0.
- `led_in` passes through a 2-flop synchronizer giving `led_s`; input-to-`led_s` latency is 2 cycles. All rules below refer to `led_s`.
- Timer saturates at all-ones and never wraps. It clears on every state change.
- L = number of consecutive cycles `led_s`=1.
- IDLE: on `led_s`=1 go to HIGH with timer=1 and blink count=0.
- HIGH: timer increments while `led_s`=1.
  - L > MAX_PULSE: go to ERR; `error_out` pulses in the cycle of the transition.
  - `led_s` falls with L >= MIN_PULSE:
    - blink count < 2^COUNT_WIDTH-1: increment the count, go to LOW.
    - blink count = 2^COUNT_WIDTH-1: overflow; go to ERR and pulse `error_out`.
  - `led_s` falls with L < MIN_PULSE: glitch; count unchanged, go to LOW.
- LOW: timer increments while `led_s`=0.
  - `led_s`=1: go to HIGH with timer=1; count is retained.
  - Timer reaches GAP_CYCLES: go to IDLE.
    - Blink count != 0: `count_out` <= count and `valid_out`=1 for exactly that cycle.
    - Blink count = 0 (burst of glitches only): no strobe.
- ERR: count cleared; `busy_out`=0. Stay until `led_s` has been 0 for GAP_CYCLES consecutive cycles, then go to IDLE. A high sample restarts the low count.
- `valid_out` and `error_out` are never high in the same cycle.
- `count_out` changes only on a `valid_out` cycle or on reset.
- `busy_out` = (state==HIGH || state==LOW), registered.
- Reset mid-burst aborts immediately; no strobe is produced. After release, decoding restarts from IDLE; a partial pulse seen after release is counted from its first sampled cycle.

Optional Feature:
- Macro LED_DEC_GLITCH_FILTER_EN.
- Defined: after the synchronizer, `led_s` changes only when the raw synchronized value has differed from it for 4 consecutive cycles. Pulses or dropouts of 3 cycles or less are invisible to the FSM. Latency rises to 6 cycles. The filter flops reset to 0.
- Undefined: `led_s` is the synchronizer output directly; latency is 2 cycles.

Test Plan:
- 5 pulses of 1600 high / 1599 low, then 8000 low -> exactly one `valid_out`, `count_out`=5, `error_out` never set, `busy_out` low after the strobe.
- 3 pulses of 1600 high, with a 100-cycle high glitch inserted in one gap -> `count_out`=3.
- A single 50-cycle pulse followed by 8000 low -> no `valid_out`, `count_out` keeps its prior value.
- `led_in` high for 4000 cycles -> one `error_out` pulse at L=3201. No `valid_out` follows. The block returns to IDLE 4000 low cycles after `led_in` falls.
- 16 legal pulses in one burst -> `error_out` on the 16th falling edge, no `valid_out`. A following 2-pulse burst decodes `count_out`=2.
- `reset_in` asserted after 2 of 5 pulses -> no strobe; a full 4-pulse burst after release gives `count_out`=4.
- With LED_DEC_GLITCH_FILTER_EN, a 2-cycle dropout inside a 1600-cycle pulse -> counted as one blink.

Source files
------------

// File: rtl/led_blink_decoder.sv
// led_blink_decoder: receive end of the Fibonacci LED blink link.
// Counts qualified high pulses on led_in; a long low gap closes the burst
// and presents the count on count_out with a one-cycle valid_out strobe.
// Optional: define LED_DEC_GLITCH_FILTER_EN to add a 4-cycle debounce
// filter after the synchronizer (input latency becomes 6 cycles).
module led_blink_decoder #(
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned TIMER_WIDTH = 14,
  parameter int unsigned MIN_PULSE   = 800,
  parameter int unsigned MAX_PULSE   = 3200,
  parameter int unsigned GAP_CYCLES  = 4000
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   led_in,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   valid_out,
  output logic                   error_out,
  output logic                   busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERR} state_e;

  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = {TIMER_WIDTH{1'b1}};
  localparam logic [TIMER_WIDTH-1:0] MIN_T     = TIMER_WIDTH'(MIN_PULSE);
  localparam logic [TIMER_WIDTH-1:0] MAX_T     = TIMER_WIDTH'(MAX_PULSE);
  localparam logic [TIMER_WIDTH-1:0] GAP_T     = TIMER_WIDTH'(GAP_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic                   led_s;
  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic [COUNT_WIDTH-1:0] blink_q, blink_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  // Two-flop synchronizer next values
  always_comb begin
    sync1_d = led_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef LED_DEC_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] fcnt_q, fcnt_d;

  // Debounce: follow the synchronized input only after 4 consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = 2'd0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == 2'd3) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 2'd1;
      end
    end
  end

  // Debounce filter flops
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      filt_q <= 1'b0;
      fcnt_q <= 2'd0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign led_s = filt_q;
`else
  assign led_s = sync2_q;
`endif

  // Saturating timer increment
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_WIDTH'(1);

  // FSM state register
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (led_s) state_d = S_HIGH;
      S_HIGH: begin
        if (led_s) begin
          if (timer_inc > MAX_T) state_d = S_ERR;
        end else if (timer_q >= MIN_T && blink_q == COUNT_MAX) begin
          state_d = S_ERR;
        end else begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (led_s) state_d = S_HIGH;
        else if (timer_inc >= GAP_T) state_d = S_IDLE;
      end
      S_ERR: if (!led_s && timer_inc >= GAP_T) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    timer_d = '0;
    blink_d = blink_q;
    count_d = count_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    busy_d  = (state_d == S_HIGH) || (state_d == S_LOW);
    if (state_d != state_q) begin
      timer_d = (state_d == S_HIGH) ? TIMER_WIDTH'(1) : '0;
    end else if (state_q == S_HIGH || state_q == S_LOW) begin
      timer_d = timer_inc;
    end else if (state_q == S_ERR && !led_s) begin
      timer_d = timer_inc;
    end
    if (state_q == S_IDLE && state_d == S_HIGH) begin
      blink_d = '0;
    end
    if (state_q == S_HIGH && state_d == S_LOW && timer_q >= MIN_T) begin
      blink_d = blink_q + COUNT_WIDTH'(1);
    end
    if (state_d == S_ERR) begin
      blink_d = '0;
    end
    if (state_q == S_HIGH && state_d == S_ERR) begin
      error_d = 1'b1;
    end
    if (state_q == S_LOW && state_d == S_IDLE && blink_q != '0) begin
      valid_d = 1'b1;
      count_d = blink_q;
    end
  end

  // Datapath and output flops
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      timer_q <= '0;
      blink_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      blink_q <= blink_d;
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign count_out = count_q;
  assign valid_out = valid_q;
  assign error_out = error_q;
  assign busy_out  = busy_q;

endmodule
